mem_port_arb: RTL

//  Arbiter/sequencer for the single-port unified memory of the DLX pipeline. Two requesters share it:

---
 rtl/mem_port_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------------------------
// mem_port_arb
// Arbiter/sequencer for the single-port unified memory of the DLX pipeline. Instruction fetch
// (IF) and data access (LW/SW) share one memory. One requester is granted at a time. Each grant
// runs a fixed-latency memory cycle, and completion is reported with a one-cycle ack. Data
// requests win by default, but fetch is forced through after FETCH_STARVE_MAX consecutive data
// grants while IF waits. A data address with the MSB set is rejected with dm_ack+dm_err and no
// memory cycle.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_if_req/i_if_addr        fetch request (held until ack) and address
//   o_if_rdata/o_if_ack       fetched word (held after ack), one-cycle completion pulse
//   o_stall_if                i_if_req & ~o_if_ack
//   i_dm_req/we/addr/wdata    data request (held until ack), store flag, address, store data
//   o_dm_rdata/ack/err        load data (held), completion pulse, rejection flag
//   o_mem_cs/we/addr/wdata    registered memory controls, word-aligned address
//   i_mem_rdata               memory read data, sampled on the last access cycle
//   o_busy                    access in flight
// ---------------------------------------------------------------------------------------------
module mem_port_arb #(
    parameter int AW               = 32,
    parameter int DW               = 32,
    parameter int MEM_LAT          = 2,
    parameter int FETCH_STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic [DW-1:0] o_if_rdata,
    output logic          o_if_ack,
    output logic          o_stall_if,
    input  logic          i_dm_req,
    input  logic          i_dm_we,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_dm_ack,
    output logic          o_dm_err,
    output logic          o_mem_cs,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (FETCH_STARVE_MAX > 0) ? $clog2(FETCH_STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FETCH_STARVE_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_streak;
    logic          r_if_ack;
    logic          r_dm_ack;
    logic          r_dm_err;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_mem_cs;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic w_idle;
    logic w_if_elig;
    logic w_dm_elig;
    logic w_grant_fetch;
    logic w_grant_data;
    logic w_dm_illegal;

    // A requester whose ack is high this cycle is still holding req from the finished access;
    // masking it keeps that stale request from being granted a second time.
    always_comb begin
        w_idle        = (r_state == S_IDLE);
        w_if_elig     = i_if_req & ~r_if_ack;
        w_dm_elig     = i_dm_req & ~r_dm_ack;
        w_grant_fetch = w_idle & w_if_elig & ((r_streak == STREAK_MAX) | ~w_dm_elig);
        w_grant_data  = w_idle & w_dm_elig & ~w_grant_fetch;
        w_dm_illegal  = i_dm_addr[AW-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_dm_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_dm_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_fetch) begin
                        r_state    <= S_FETCH;
                        r_mem_cs   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {i_if_addr[AW-1:2], 2'b00};
                        r_cnt      <= CNT_INIT;
                    end else if (w_grant_data) begin
                        if (w_dm_illegal) begin
                            // Rejected without touching memory; answer next cycle.
                            r_dm_ack <= 1'b1;
                            r_dm_err <= 1'b1;
                        end else begin
                            r_state     <= S_DATA;
                            r_mem_cs    <= 1'b1;
                            r_mem_we    <= i_dm_we;
                            r_mem_addr  <= {i_dm_addr[AW-1:2], 2'b00};
                            r_mem_wdata <= i_dm_wdata;
                            r_cnt       <= CNT_INIT;
                        end
                    end
                end
                S_DATA, S_FETCH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_mem_cs <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (r_state == S_FETCH) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end else begin
                            r_dm_ack <= 1'b1;
                            // r_mem_we still flags a store during the access.
                            if (!r_mem_we) begin
                                r_dm_rdata <= i_mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_cs <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase

            // Count data grants that bypassed a waiting fetch.
            if (!i_if_req || w_grant_fetch) begin
                r_streak <= '0;
            end else if (w_grant_data && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

    always_comb begin
        o_if_rdata  = r_if_rdata;
        o_if_ack    = r_if_ack;
        o_stall_if  = i_if_req & ~r_if_ack;
        o_dm_rdata  = r_dm_rdata;
        o_dm_ack    = r_dm_ack;
        o_dm_err    = r_dm_err;
        o_mem_cs    = r_mem_cs;
        o_mem_we    = r_mem_we;
        o_mem_addr  = r_mem_addr;
        o_mem_wdata = r_mem_wdata;
        o_busy      = (r_state != S_IDLE);
    end

endmodule
